// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: master-side requests and slave-side bus of the two-master arbiter
// slave modport: the arbiter's view (master and slave-data inputs in, mux outputs and stalls out)
// master modport: the environment's view (drives requests and slave read data, observes outputs)
interface bus_arbiter_if;
    logic        i_m0_cyc, i_m1_cyc;
    logic        i_m0_we, i_m1_we;
    logic [15:0] i_m0_addr, i_m1_addr;
    logic [15:0] i_m0_dat, i_m1_dat;
    logic        i_m0_lock, i_m1_lock;
    logic        o_m0_stall, o_m1_stall;
    logic [15:0] o_m_dat;
    logic        o_s_cyc;
    logic        o_s_we;
    logic [15:0] o_s_addr;
    logic [15:0] o_s_dat;
    logic [15:0] i_s_dat;
    logic        o_owner;
    modport slave (
        input  i_m0_cyc, i_m1_cyc, i_m0_we, i_m1_we, i_m0_addr, i_m1_addr,
               i_m0_dat, i_m1_dat, i_m0_lock, i_m1_lock, i_s_dat,
        output o_m0_stall, o_m1_stall, o_m_dat, o_s_cyc, o_s_we, o_s_addr,
               o_s_dat, o_owner
    );
    modport master (
        output i_m0_cyc, i_m1_cyc, i_m0_we, i_m1_we, i_m0_addr, i_m1_addr,
               i_m0_dat, i_m1_dat, i_m0_lock, i_m1_lock, i_s_dat,
        input  o_m0_stall, o_m1_stall, o_m_dat, o_s_cyc, o_s_we, o_s_addr,
               o_s_dat, o_owner
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter, parked grant, round-robin on release, burst limit with lock
// Ports: i_clk system clock; i_reset async active-high reset;
//        bus (slave modport): m0/m1 cyc/we/addr/dat/lock in, per-master stall out,
//        slave-side cyc/we/addr/dat out, slave read data in and broadcast as o_m_dat, o_owner grant.
module bus_arbiter #(
    parameter int MAXBURST = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    bus_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAXBURST);
    localparam logic [CW-1:0] LIMIT = CW'(MAXBURST - 1);
    typedef enum logic {OWN_M0 = 1'b0, OWN_M1 = 1'b1} owner_e;
    owner_e        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          own_cyc, oth_cyc, own_lock, contend, preempt, release_bus;
    always_comb begin
        own_cyc     = owner_q == OWN_M1 ? bus.i_m1_cyc : bus.i_m0_cyc;
        oth_cyc     = owner_q == OWN_M1 ? bus.i_m0_cyc : bus.i_m1_cyc;
        own_lock    = owner_q == OWN_M1 ? bus.i_m1_lock : bus.i_m0_lock;
        contend     = own_cyc & oth_cyc;
        // the limiting transfer still completes; the grant moves at the edge after it
        preempt     = contend & (cnt_q == LIMIT) & ~own_lock;
        release_bus = ~own_cyc & oth_cyc;
        owner_d     = (preempt | release_bus) ? (owner_q == OWN_M1 ? OWN_M0 : OWN_M1) : owner_q;
        // count only contended transfers; saturate while a locked owner keeps the bus
        cnt_d       = (contend & ~preempt) ? (cnt_q == LIMIT ? cnt_q : cnt_q + 1'b1) : '0;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            owner_q <= OWN_M0;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end
    // reset forces the owner off the bus without waiting for a clock edge
    assign bus.o_s_cyc    = own_cyc & ~i_reset;
    assign bus.o_s_we     = owner_q == OWN_M1 ? bus.i_m1_we : bus.i_m0_we;
    assign bus.o_s_addr   = owner_q == OWN_M1 ? bus.i_m1_addr : bus.i_m0_addr;
    assign bus.o_s_dat    = owner_q == OWN_M1 ? bus.i_m1_dat : bus.i_m0_dat;
    assign bus.o_m0_stall = bus.i_m0_cyc & (owner_q != OWN_M0 | i_reset);
    assign bus.o_m1_stall = bus.i_m1_cyc & (owner_q != OWN_M1 | i_reset);
    assign bus.o_m_dat    = bus.i_s_dat;
    assign bus.o_owner    = owner_q;
endmodule
